// File: rtl/dm_spi_bank_if.sv
// Register bus between an APB bridge (master) and the SPI bank (slave).
interface dm_spi_bank_if #(
  parameter int unsigned ADDRW = 14
);
  logic [ADDRW-1:0] RamBusAddress;
  logic [31:0]      RamBusDataIn;
  logic             RamBusnCs;
  logic             RamBusWrnRd;
  logic             RamBusLatch;
  logic [31:0]      RamBusDataOut;
  logic             RamBusAck;

  modport master (
    output RamBusAddress, RamBusDataIn, RamBusnCs, RamBusWrnRd, RamBusLatch,
    input  RamBusDataOut, RamBusAck
  );

  modport slave (
    input  RamBusAddress, RamBusDataIn, RamBusnCs, RamBusWrnRd, RamBusLatch,
    output RamBusDataOut, RamBusAck
  );
endinterface

// File: rtl/dm_spi_bank.sv
// Bank of lockstep SPI masters (mode 0) with shadowed TX words, optional
// PPS-aligned start and a register bus with a single wait state.
module dm_spi_bank #(
  parameter int unsigned NCHAN  = 6,
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned NCS    = 4,
  parameter int unsigned CLKDIV = 4,
  parameter int unsigned ADDRW  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  dm_spi_bank_if.slave          bus,
  input  logic                  PPS,
  output logic [NCHAN-1:0]      Sck,
  output logic [NCHAN-1:0]      Mosi,
  input  logic [NCHAN-1:0]      Miso,
  output logic [NCHAN*NCS-1:0]  nCs,
  output logic                  Busy,
  output logic [2:0]            StateOut
);

  localparam int unsigned WIDXW = ADDRW - 2;
  localparam int unsigned DIVW  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int unsigned BITW  = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t state, stateNext;

  logic             ack, done, access, wrEn, ctrlWr, statusWr, goReq, ppsEff;
  logic [2:0]       csEff, csSel;
  logic [WIDXW-1:0] wordIdx;
  logic [31:0]      rdData, dataOut;
  logic             ppsMode, overrun;
  logic [2:0]       csIdx;
  logic [7:0]       xferCnt;
  logic [WIDTH-1:0] txShadow [NCHAN];
  logic [WIDTH-1:0] rxReg    [NCHAN];
  logic [WIDTH-1:0] shiftReg [NCHAN];
  logic [WIDTH-1:0] rxShift  [NCHAN];
  logic             ppsS1, ppsS2, ppsS3, ppsRise;
  logic [DIVW-1:0]  divCnt;
  logic             divDone;
  logic [BITW-1:0]  bitCnt;
  logic             sck, riseEv, fallEv, loadEnter, holdDone;
  logic             unusedBits;

  assign access    = bus.RamBusnCs & bus.RamBusLatch;
  assign wordIdx   = bus.RamBusAddress[ADDRW-1:2];
  assign wrEn      = ack & access & bus.RamBusWrnRd;
  assign ctrlWr    = wrEn & (wordIdx == '0);
  assign statusWr  = wrEn & (wordIdx == WIDXW'(1));
  assign goReq     = ctrlWr & bus.RamBusDataIn[0];
  // A CTRL write carrying GO uses its own PPSMODE/CsIdx fields.
  assign ppsEff    = ctrlWr ? bus.RamBusDataIn[1] : ppsMode;
  assign csEff     = ctrlWr ? bus.RamBusDataIn[10:8] : csIdx;
  assign csSel     = (32'(csEff) < NCS) ? csEff : 3'd0;
  assign divDone   = (divCnt == DIVW'(CLKDIV - 1));
  assign ppsRise   = ppsS2 & ~ppsS3;
  assign loadEnter = (stateNext == LOAD) && (state != LOAD);
  assign holdDone  = (state == HOLD) && divDone;
  assign unusedBits = ^{bus.RamBusAddress[1:0], bus.RamBusDataIn};

  assign bus.RamBusAck     = ack;
  assign bus.RamBusDataOut = dataOut;
  assign Sck               = {NCHAN{sck}};
  assign StateOut          = state;

  // Bus handshake: Ack in the second access cycle, read data only while Ack is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack     <= 1'b0;
      done    <= 1'b0;
      dataOut <= '0;
    end else begin
      ack     <= access & ~ack & ~done;
      done    <= access & (ack | done);
      dataOut <= (access & ~ack & ~done) ? rdData : '0;
    end
  end

  // Read mux; unmapped words and channels beyond NCHAN return zero.
  always_comb begin
    rdData = '0;
    if (wordIdx == '0) begin
      rdData = {21'd0, csIdx, 6'd0, ppsMode, 1'b0};
    end else if (wordIdx == WIDXW'(1)) begin
      rdData = {16'd0, xferCnt, 5'd0, overrun, (state == ARM), Busy};
    end
    for (int n = 0; n < int'(NCHAN); n++) begin
      if ((4 + n) < 16 && wordIdx == WIDXW'(4 + n)) rdData = 32'(txShadow[n]);
      if (wordIdx == WIDXW'(16 + n)) rdData = 32'(rxReg[n]);
    end
  end

  // Control/status registers, TX shadows and RX results.
  always_ff @(posedge clk) begin
    if (rst) begin
      ppsMode <= 1'b0;
      csIdx   <= 3'd0;
      overrun <= 1'b0;
      xferCnt <= 8'd0;
      for (int n = 0; n < int'(NCHAN); n++) begin
        txShadow[n] <= '0;
        rxReg[n]    <= '0;
      end
    end else begin
      if (ctrlWr) begin
        ppsMode <= bus.RamBusDataIn[1];
        csIdx   <= bus.RamBusDataIn[10:8];
      end
      if (statusWr && bus.RamBusDataIn[2]) overrun <= 1'b0;
      else if (goReq && state != IDLE)     overrun <= 1'b1;
      if (holdDone) begin
        xferCnt <= xferCnt + 8'd1;
        for (int n = 0; n < int'(NCHAN); n++) rxReg[n] <= rxShift[n];
      end
      for (int n = 0; n < int'(NCHAN); n++) begin
        if (wrEn && (4 + n) < 16 && wordIdx == WIDXW'(4 + n))
          txShadow[n] <= bus.RamBusDataIn[WIDTH-1:0];
      end
    end
  end

  // PPS two-flop synchroniser plus edge-detect stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ppsS1 <= 1'b0;
      ppsS2 <= 1'b0;
      ppsS3 <= 1'b0;
    end else begin
      ppsS1 <= PPS;
      ppsS2 <= ppsS1;
      ppsS3 <= ppsS2;
    end
  end

  // FSM state register; Busy tracks any non-idle state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      Busy  <= 1'b0;
    end else begin
      state <= stateNext;
      Busy  <= (stateNext != IDLE);
    end
  end

  // FSM next state and SCK phase events.
  always_comb begin
    stateNext = state;
    riseEv    = 1'b0;
    fallEv    = 1'b0;
    unique case (state)
      IDLE:  if (goReq) stateNext = ppsEff ? ARM : LOAD;
      ARM:   if (ppsRise) stateNext = LOAD;
      LOAD:  stateNext = SHIFT;
      SHIFT: begin
        if (divDone) begin
          if (!sck) begin
            riseEv = 1'b1;
          end else begin
            fallEv = 1'b1;
            if (bitCnt == BITW'(WIDTH - 1)) stateNext = HOLD;
          end
        end
      end
      HOLD:  if (divDone) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Shift datapath: load on LOAD entry, sample on SCK rise, advance on SCK fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck    <= 1'b0;
      Mosi   <= '0;
      nCs    <= '1;
      divCnt <= '0;
      bitCnt <= '0;
      for (int n = 0; n < int'(NCHAN); n++) begin
        shiftReg[n] <= '0;
        rxShift[n]  <= '0;
      end
    end else begin
      if (state == SHIFT || state == HOLD) divCnt <= divDone ? '0 : divCnt + DIVW'(1);
      else                                 divCnt <= '0;

      if (loadEnter) begin
        sck    <= 1'b0;
        bitCnt <= '0;
        for (int n = 0; n < int'(NCHAN); n++) begin
          shiftReg[n] <= txShadow[n];
          Mosi[n]     <= txShadow[n][WIDTH-1];
          for (int k = 0; k < int'(NCS); k++)
            nCs[n*NCS + k] <= (k == int'(csSel)) ? 1'b0 : 1'b1;
        end
      end else if (riseEv) begin
        sck <= 1'b1;
        for (int n = 0; n < int'(NCHAN); n++)
          rxShift[n] <= {rxShift[n][WIDTH-2:0], Miso[n]};
      end else if (fallEv) begin
        sck    <= 1'b0;
        bitCnt <= bitCnt + BITW'(1);
        for (int n = 0; n < int'(NCHAN); n++) begin
          shiftReg[n] <= {shiftReg[n][WIDTH-2:0], 1'b0};
          Mosi[n]     <= shiftReg[n][WIDTH-2];
        end
      end else if (holdDone) begin
        nCs  <= '1;
        Mosi <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dm_spi_bank.sv
// Directed bench for dm_spi_bank with MISO looped back to MOSI.
module tb_dm_spi_bank;
  localparam int unsigned NCHAN  = 6;
  localparam int unsigned WIDTH  = 24;
  localparam int unsigned NCS    = 4;
  localparam int unsigned CLKDIV = 2;
  localparam int unsigned ADDRW  = 14;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 PPS;
  logic [NCHAN-1:0]     Sck, Mosi, Miso;
  logic [NCHAN*NCS-1:0] nCs;
  logic                 Busy;
  logic [2:0]           StateOut;

  int checks = 0;
  int errors = 0;

  dm_spi_bank_if #(.ADDRW(ADDRW)) bus();

  dm_spi_bank #(
    .NCHAN(NCHAN), .WIDTH(WIDTH), .NCS(NCS), .CLKDIV(CLKDIV), .ADDRW(ADDRW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .PPS(PPS),
    .Sck(Sck), .Mosi(Mosi), .Miso(Miso), .nCs(nCs),
    .Busy(Busy), .StateOut(StateOut)
  );

  assign Miso = Mosi;

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] txVal(input int n);
    return (32'h00C3_5A00 ^ (32'(n) * 32'h0001_1111)) & 32'h00FF_FFFF;
  endfunction

  // One APB-style access; returns at the commit edge (+1).
  task automatic busXfer(input int a, input logic [31:0] d, input logic wr,
                         output logic [31:0] rd, output int ackAt);
    rd = '0;
    ackAt = 0;
    @(posedge clk); #1;
    bus.RamBusAddress = ADDRW'(a);
    bus.RamBusDataIn  = d;
    bus.RamBusWrnRd   = wr;
    bus.RamBusnCs     = 1'b1;
    bus.RamBusLatch   = 1'b0;
    @(posedge clk); #1;
    bus.RamBusLatch   = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus.RamBusAck) begin
        ackAt = i;
        rd = bus.RamBusDataOut;
        break;
      end
    end
    if (ackAt == 0) checkVal("ack timeout", 32'(ackAt), 32'd2);
    @(posedge clk); #1;
    bus.RamBusnCs   = 1'b0;
    bus.RamBusLatch = 1'b0;
    bus.RamBusWrnRd = 1'b0;
  endtask

  task automatic busWr(input int a, input logic [31:0] d);
    logic [31:0] rd;
    int at;
    busXfer(a, d, 1'b1, rd, at);
  endtask

  task automatic busRd(input int a, output logic [31:0] d);
    int at;
    busXfer(a, 32'd0, 1'b0, d, at);
  endtask

  // Follow one transfer until the selected nCs rises again.
  task automatic watchXfer(input int csSel, output int lowCnt, output logic [31:0] bits,
                           output int nBits, output logic bad);
    logic [NCHAN*NCS-1:0] pat;
    logic prevSck;
    pat = '1;
    for (int n = 0; n < int'(NCHAN); n++) pat[n*NCS + csSel] = 1'b0;
    lowCnt = 0; bits = '0; nBits = 0; bad = 1'b0; prevSck = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (nCs !== '1 && nCs !== pat) bad = 1'b1;
      if (Sck !== '0 && Sck !== '1) bad = 1'b1;
      if (!nCs[csSel]) lowCnt++;
      if (Sck[0] && !prevSck) begin
        bits = {bits[30:0], Mosi[0]};
        nBits++;
      end
      prevSck = Sck[0];
      if (lowCnt > 0 && nCs[csSel]) break;
    end
  endtask

  task automatic waitIdle();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (StateOut == 3'd0) break;
    end
    checkVal("idle", 32'(StateOut), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, bits;
    int lowCnt, nBits, at, rises, viol, lat;
    logic bad, prev;

    rst = 1'b1;
    PPS = 1'b0;
    bus.RamBusAddress = '0;
    bus.RamBusDataIn  = '0;
    bus.RamBusnCs     = 1'b0;
    bus.RamBusWrnRd   = 1'b0;
    bus.RamBusLatch   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    checkVal("rst nCs", 32'(nCs), 32'h00FF_FFFF);
    checkVal("rst Sck", 32'(Sck), 32'd0);
    checkVal("rst Busy", 32'(Busy), 32'd0);
    checkVal("rst state", 32'(StateOut), 32'd0);
    checkVal("rst ack", 32'(bus.RamBusAck), 32'd0);
    checkVal("rst dout", bus.RamBusDataOut, 32'd0);
    busRd(32'h04, rd); checkVal("rst STATUS", rd, 32'd0);
    busRd(32'h00, rd); checkVal("rst CTRL", rd, 32'd0);

    // Reset at bit 10 aborts the transfer
    busWr(32'h10, 32'h00A5_F00F);
    busWr(32'h00, 32'h1);
    rises = 0; prev = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (Sck[0] && !prev) rises++;
      prev = Sck[0];
      if (rises == 10) break;
    end
    checkVal("abort reach bit10", 32'(rises), 32'd10);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkVal("abort nCs", 32'(nCs), 32'h00FF_FFFF);
    checkVal("abort Sck", 32'(Sck), 32'd0);
    checkVal("abort state", 32'(StateOut), 32'd0);
    busRd(32'h40, rd); checkVal("abort RX0", rd, 32'd0);
    busRd(32'h04, rd); checkVal("abort STATUS", rd, 32'd0);

    // Basic transfer, latency and bit order
    busWr(32'h10, 32'h00A5_F00F);
    busXfer(32'h00, 32'h1, 1'b1, rd, at);
    checkVal("go ack cycle", 32'(at), 32'd2);
    watchXfer(0, lowCnt, bits, nBits, bad);
    checkVal("main nCs low", 32'(lowCnt), 32'd99);
    checkVal("main mosi", 32'(bits[23:0]), 32'h00A5_F00F);
    checkVal("main bits", 32'(nBits), 32'd24);
    checkVal("main lockstep", 32'(bad), 32'd0);
    busRd(32'h40, rd); checkVal("main RX0", rd, 32'h00A5_F00F);
    busRd(32'h44, rd); checkVal("main RX1", rd, 32'd0);
    busRd(32'h04, rd); checkVal("main STATUS", rd, 32'h0000_0100);

    // GO and TX write during SHIFT
    busWr(32'h10, 32'h0012_3456);
    busWr(32'h00, 32'h1);
    repeat (20) @(negedge clk);
    busRd(32'h04, rd); checkVal("ovr busy STATUS", rd, 32'h0000_0101);
    busWr(32'h00, 32'h1);
    busWr(32'h10, 32'h000F_0F0F);
    watchXfer(0, lowCnt, bits, nBits, bad);
    checkVal("ovr lockstep", 32'(bad), 32'd0);
    repeat (6) @(negedge clk);
    checkVal("ovr no restart", 32'(StateOut), 32'd0);
    busRd(32'h40, rd); checkVal("ovr RX0", rd, 32'h0012_3456);
    busRd(32'h04, rd); checkVal("ovr STATUS", rd, 32'h0000_0204);
    busWr(32'h04, 32'h4);
    busRd(32'h04, rd); checkVal("ovr cleared", rd, 32'h0000_0200);

    // Chip-select index, including out-of-range index
    busWr(32'h00, 32'h301);
    watchXfer(3, lowCnt, bits, nBits, bad);
    checkVal("cs3 nCs low", 32'(lowCnt), 32'd99);
    checkVal("cs3 pattern", 32'(bad), 32'd0);
    busRd(32'h40, rd); checkVal("cs3 RX0 new tx", rd, 32'h000F_0F0F);
    busWr(32'h00, 32'h501);
    watchXfer(0, lowCnt, bits, nBits, bad);
    checkVal("cs5 nCs low", 32'(lowCnt), 32'd99);
    checkVal("cs5 pattern", 32'(bad), 32'd0);
    busRd(32'h00, rd); checkVal("ctrl readback", rd, 32'h0000_0500);
    busWr(32'h40, 32'hDEAD);
    busRd(32'h40, rd); checkVal("RX read-only", rd, 32'h000F_0F0F);

    // PPS-armed start, all channels together
    for (int n = 0; n < int'(NCHAN); n++) busWr(32'h10 + 4*n, txVal(n));
    busWr(32'h00, 32'h3);
    busRd(32'h04, rd); checkVal("pps armed STATUS", rd, 32'h0000_0403);
    viol = 0;
    repeat (1000) begin
      @(negedge clk);
      if (Sck !== '0 || nCs !== '1 || StateOut != 3'd1) viol++;
    end
    checkVal("pps quiet", 32'(viol), 32'd0);
    @(posedge clk); #3 PPS = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (StateOut == 3'd2) begin
        lat = k;
        break;
      end
    end
    checkVal("pps latency<=3", 32'(lat >= 1 && lat <= 3), 32'd1);
    watchXfer(0, lowCnt, bits, nBits, bad);
    PPS = 1'b0;
    checkVal("pps nCs low", 32'(lowCnt), 32'd99);
    checkVal("pps lockstep", 32'(bad), 32'd0);
    checkVal("pps mosi", 32'(bits[23:0]), txVal(0));
    for (int n = 0; n < int'(NCHAN); n++) begin
      busRd(32'h40 + 4*n, rd);
      checkVal($sformatf("pps RX%0d", n), rd, txVal(n));
    end

    // Transfer counter wrap
    busWr(32'h00, 32'h0);
    for (int i = 0; i < 250; i++) begin
      busWr(32'h00, 32'h1);
      waitIdle();
    end
    busRd(32'h04, rd); checkVal("count 255", rd, 32'h0000_FF00);
    busWr(32'h00, 32'h1);
    waitIdle();
    busRd(32'h04, rd); checkVal("count wrap", rd, 32'd0);

    // Unmapped reads
    busXfer(32'h3C, 32'd0, 1'b0, rd, at);
    checkVal("rd 0x3C", rd, 32'd0);
    checkVal("rd 0x3C ack cycle", 32'(at), 32'd2);
    @(negedge clk);
    checkVal("rd 0x3C ack single", 32'(bus.RamBusAck), 32'd0);
    busXfer(32'h40 + 4*NCHAN, 32'd0, 1'b0, rd, at);
    checkVal("rd RX[NCHAN]", rd, 32'd0);
    checkVal("rd RX[NCHAN] ack cycle", 32'(at), 32'd2);
    @(negedge clk);
    checkVal("rd RX[NCHAN] ack single", 32'(bus.RamBusAck), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
